pipe_skid_register: RTL and testbench

- Elastic N-bit pipeline register with a two-entry skid buffer, placed between adjacent stages of the pipelined RV32 datapath (e.g. IF/ID, ID/EX).
- The upstream stage writes with valid/ready. The downstream stage reads by asserting ready, which replaces a bare load enable.
- in_ready is a registered function of state, so the stall path from downstream to upstream is fully cut and never combinational.
- Supports synchronous flush for branch/jump squash.

---
 rtl/pipe_skid_register.sv | 97 +++++++++
 tb/tb_pipe_skid_register.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_register.sv
// rtl/pipe_skid_register.sv - elastic pipeline register with two-entry skid buffer
module pipe_skid_register #(
    parameter int            N         = 32,
    parameter logic [N-1:0]  FLUSH_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    input  logic          flush,
    output logic [1:0]    occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    main_data;
    logic [N-1:0]    skid_data;
    logic            main_vld;
    logic            skid_vld;
    logic            accept;
    logic            emit;

    // Handshake outputs decode only registered valid bits, so no
    // combinational path exists from out_ready to in_ready.
    assign in_ready  = ~skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_data;
    assign occupancy = {skid_vld, main_vld & ~skid_vld};

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        main_data <= in_data;
                        main_vld  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state     <= TWO;
                        skid_data <= in_data;
                        skid_vld  <= 1'b1;
                    end else if (accept && emit) begin
                        main_data <= in_data;
                    end else if (emit) begin
                        state     <= EMPTY;
                        main_data <= FLUSH_VAL;
                        main_vld  <= 1'b0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (emit) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        skid_data <= FLUSH_VAL;
                        skid_vld  <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_data <= FLUSH_VAL;
                    skid_data <= FLUSH_VAL;
                    main_vld  <= 1'b0;
                    skid_vld  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_register.sv
// tb/tb_pipe_skid_register.sv - self-checking bench for pipe_skid_register
module tb_pipe_skid_register;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         flush;
    logic [1:0]   occupancy;

    int total;
    int bad;

    logic [31:0] ref_q[$];

    pipe_skid_register #(.N(32), .FLUSH_VAL(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] occ, input logic [31:0] data);
        check({tag, ".occ"},  {30'd0, occupancy}, {30'd0, occ});
        check({tag, ".ordy"}, {31'd0, in_ready},  {31'd0, occ != 2'd2});
        check({tag, ".oval"}, {31'd0, out_valid}, {31'd0, occ != 2'd0});
        check({tag, ".data"}, out_data, data);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
        flush = 1'b0;

        repeat (3) step();
        check_all("reset", 2'd0, 32'h0);
        rst = 1'b1;

        // streaming
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h11; step(); check_all("s11", 2'd1, 32'h11);
        in_data = 32'h22; step(); check_all("s22", 2'd1, 32'h22);
        in_data = 32'h33; step(); check_all("s33", 2'd1, 32'h33);
        in_valid = 1'b0;  step(); check_all("sdrain", 2'd0, 32'h0);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hAAAA0001; step(); check_all("bp1", 2'd1, 32'hAAAA0001);
        in_data = 32'hAAAA0002; step(); check_all("bp2", 2'd2, 32'hAAAA0001);
        in_data = 32'hAAAA0003; step(); check_all("bp3", 2'd2, 32'hAAAA0001);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); check_all("bpd1", 2'd1, 32'hAAAA0002);
        step(); check_all("bpd2", 2'd0, 32'h0);

        // simultaneous accept and emit in ONE
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h5; step(); check_all("sim5", 2'd1, 32'h5);
        out_ready = 1'b1;
        in_data = 32'h6; step(); check_all("sim6", 2'd1, 32'h6);
        in_valid = 1'b0; step(); check_all("simd", 2'd0, 32'h0);

        // flush beats a simultaneous accept
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h7; step();
        in_data = 32'h8; step(); check_all("fl_two", 2'd2, 32'h7);
        flush = 1'b1;
        in_data = 32'h9; step(); check_all("fl", 2'd0, 32'h0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); check_all("fl_after", 2'd0, 32'h0);

        // asynchronous reset while in TWO
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hB1; step();
        in_data = 32'hB2; step(); check_all("ar_two", 2'd2, 32'hB1);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_all("ar", 2'd0, 32'h0);
        step();
        rst = 1'b1;

        // random traffic against a reference queue
        ref_q.delete();
        for (int i = 0; i < 4000; i++) begin
            logic exp_acc;
            logic exp_emit;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = $urandom;
            #1;
            check_all("rnd", 2'(ref_q.size()), (ref_q.size() != 0) ? ref_q[0] : 32'h0);
            exp_acc  = in_valid && (ref_q.size() < 2);
            exp_emit = out_ready && (ref_q.size() > 0);
            @(posedge clk);
            if (flush) begin
                ref_q.delete();
            end else begin
                if (exp_emit) void'(ref_q.pop_front());
                if (exp_acc) ref_q.push_back(in_data);
            end
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        #1 check_all("rnd_end", 2'(ref_q.size()), (ref_q.size() != 0) ? ref_q[0] : 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
